// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and constants for the fetch / load-store memory port arbiter.
//   resp_owner_e : which requester owns the read data returning this cycle
//   BE_ALL       : byte-enable pattern for full-word fetch reads
//   RUN_CNT_W    : width of the data-run starvation counter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_IF   = 2'd1,
    RESP_D    = 2'd2
  } resp_owner_e;

  localparam logic [3:0] BE_ALL    = 4'b1111;
  localparam int unsigned RUN_CNT_W = 4;

endpackage

// File: rtl/arb_run_counter.sv
// arb_run_counter
// Counts consecutive data grants made while fetch is waiting and flags when
// fetch must win the next contended cycle.
// Ports:
//   clock_i          : system clock, rising edge
//   reset_i          : synchronous active-high reset
//   if_req_i         : fetch request (a idle fetch clears the run)
//   if_gnt_i         : fetch granted this cycle (clears the run)
//   d_gnt_i          : data granted this cycle (extends the run)
//   fetch_priority_o : run has reached MAX_DATA_RUN
module arb_run_counter #(
  parameter int unsigned MAX_DATA_RUN = 4
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic if_req_i,
  input  logic if_gnt_i,
  input  logic d_gnt_i,
  output logic fetch_priority_o
);
  import mem_arb_pkg::*;

  localparam logic [RUN_CNT_W-1:0] MaxRun = RUN_CNT_W'(MAX_DATA_RUN);

  logic [RUN_CNT_W-1:0] r_cnt;
  logic [RUN_CNT_W-1:0] w_cnt_next;

  always_comb begin
    w_cnt_next = r_cnt;
    if (if_gnt_i || !if_req_i) begin
      w_cnt_next = '0;
    end else if (d_gnt_i && (r_cnt < MaxRun)) begin
      // Saturate so the counter can never run past the priority threshold.
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign fetch_priority_o = (r_cnt == MaxRun);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous word memory between instruction fetch
// and the load/store path. One grant per cycle, memory command mirrors the
// winner, and the one-cycle-latency read data is steered back to its issuer.
// Ports:
//   clock_i, reset_i          : clock, synchronous active-high reset
//   if_req_i/if_addr_i        : fetch read request and word address
//   if_gnt_o                  : fetch granted (combinational)
//   if_rvalid_o/if_rdata_o    : fetch read response (one cycle after grant)
//   d_req_i/d_we_i/d_be_i     : load/store request, store flag, byte enables
//   d_addr_i/d_wdata_i        : data word address and store data
//   d_gnt_o                   : data granted (combinational)
//   d_rvalid_o/d_rdata_o      : load response (one cycle after grant)
//   mem_en_o..mem_wdata_o     : memory command
//   mem_rdata_i               : memory read data
//   stall_o                   : fetch requested but not granted
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MAX_DATA_RUN = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [3:0]            d_be_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  stall_o
);
  import mem_arb_pkg::*;

  logic        w_fetch_priority;
  logic        w_if_gnt;
  logic        w_d_gnt;
  resp_owner_e r_owner;
  resp_owner_e w_owner_next;

  // Data wins contention until the run limit is hit; reset blocks all grants.
  assign w_if_gnt = ~reset_i & if_req_i & (~d_req_i | w_fetch_priority);
  assign w_d_gnt  = ~reset_i & d_req_i & (~if_req_i | ~w_fetch_priority);

  assign if_gnt_o = w_if_gnt;
  assign d_gnt_o  = w_d_gnt;
  assign stall_o  = if_req_i & ~w_if_gnt;

  arb_run_counter #(
    .MAX_DATA_RUN (MAX_DATA_RUN)
  ) u_run_counter (
    .clock_i          (clock_i),
    .reset_i          (reset_i),
    .if_req_i         (if_req_i),
    .if_gnt_i         (w_if_gnt),
    .d_gnt_i          (w_d_gnt),
    .fetch_priority_o (w_fetch_priority)
  );

  // Memory command mux. Non-enabled fields default to the fetch view.
  always_comb begin
    mem_en_o    = w_if_gnt | w_d_gnt;
    mem_we_o    = 1'b0;
    mem_be_o    = BE_ALL;
    mem_addr_o  = if_addr_i;
    mem_wdata_o = '0;
    if (w_d_gnt) begin
      mem_we_o    = d_we_i;
      mem_be_o    = d_be_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
    end
  end

  // Response owner FSM: state register.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_owner <= RESP_NONE;
    end else begin
      r_owner <= w_owner_next;
    end
  end

  // Response owner FSM: next state. Stores complete at grant.
  always_comb begin
    w_owner_next = RESP_NONE;
    if (w_if_gnt) begin
      w_owner_next = RESP_IF;
    end else if (w_d_gnt && !d_we_i) begin
      w_owner_next = RESP_D;
    end
  end

  // Response owner FSM: outputs. Non-owner read data is held at zero.
  always_comb begin
    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    d_rvalid_o  = 1'b0;
    d_rdata_o   = '0;
    unique case (r_owner)
      RESP_IF: begin
        if_rvalid_o = 1'b1;
        if_rdata_o  = mem_rdata_i;
      end
      RESP_D: begin
        d_rvalid_o = 1'b1;
        d_rdata_o  = mem_rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter: a behavioural memory drives
// mem_rdata_i, an abstract arbitration/response model is checked every
// cycle, and hand-computed literal expectations pin the model.
module tb_mem_port_arbiter;

  localparam int unsigned MaxRun = 4;

  logic        clock;
  logic        reset;
  logic        if_req;
  logic [11:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [11:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall;

  mem_port_arbiter #(
    .ADDR_WIDTH   (12),
    .DATA_WIDTH   (32),
    .MAX_DATA_RUN (MaxRun)
  ) dut (
    .clock_i     (clock),
    .reset_i     (reset),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_gnt_o    (if_gnt),
    .if_rvalid_o (if_rvalid),
    .if_rdata_o  (if_rdata),
    .d_req_i     (d_req),
    .d_we_i      (d_we),
    .d_be_i      (d_be),
    .d_addr_i    (d_addr),
    .d_wdata_i   (d_wdata),
    .d_gnt_o     (d_gnt),
    .d_rvalid_o  (d_rvalid),
    .d_rdata_o   (d_rdata),
    .mem_en_o    (mem_en),
    .mem_we_o    (mem_we),
    .mem_be_o    (mem_be),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .stall_o     (stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Bench memory (driven by the DUT's command) and reference memory (driven
  // by the model's own idea of who won).
  logic [31:0] mem     [4096];
  logic [31:0] ref_mem [4096];

  // Model state: run length of data wins, pending response owner and data.
  int          m_run;
  int          m_pend;  // 0 none, 1 fetch, 2 data
  logic [31:0] m_pdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  // 0 = nobody, 1 = fetch, 2 = data.
  function automatic int winner();
    if (reset) return 0;
    if (if_req && d_req) return (m_run >= int'(MaxRun)) ? 1 : 2;
    if (if_req) return 1;
    if (d_req) return 2;
    return 0;
  endfunction

  task automatic compare_model();
    int w;
    w = winner();
    chkb("if_gnt", if_gnt, w == 1);
    chkb("d_gnt", d_gnt, w == 2);
    chkb("stall", stall, if_req && (w != 1));
    chkb("mem_en", mem_en, w != 0);
    if (w == 1) begin
      chk("mem_addr_if", 32'(mem_addr), 32'(if_addr));
      chkb("mem_we_if", mem_we, 1'b0);
      chk("mem_be_if", 32'(mem_be), 32'hF);
    end else if (w == 2) begin
      chk("mem_addr_d", 32'(mem_addr), 32'(d_addr));
      chkb("mem_we_d", mem_we, d_we);
      chk("mem_be_d", 32'(mem_be), 32'(d_be));
      if (d_we) chk("mem_wdata", mem_wdata, d_wdata);
    end
    chkb("if_rvalid", if_rvalid, m_pend == 1);
    chk("if_rdata", if_rdata, (m_pend == 1) ? m_pdata : 32'h0);
    chkb("d_rvalid", d_rvalid, m_pend == 2);
    chk("d_rdata", d_rdata, (m_pend == 2) ? m_pdata : 32'h0);
  endtask

  // Wait to mid-cycle and check the model; caller may add literal checks.
  task automatic settle();
    @(negedge clock);
    compare_model();
  endtask

  // Clock edge: update bench memory from the DUT command sampled before the
  // edge settles, then advance the model, then release inputs for driving.
  task automatic tick();
    logic        c_en;
    logic        c_we;
    logic [3:0]  c_be;
    logic [11:0] c_addr;
    logic [31:0] c_wd;
    int          w;
    @(posedge clock);
    c_en   = mem_en;
    c_we   = mem_we;
    c_be   = mem_be;
    c_addr = mem_addr;
    c_wd   = mem_wdata;
    w      = winner();
    if (c_en) begin
      if (c_we) mem[c_addr] = merge(mem[c_addr], c_wd, c_be);
      else mem_rdata = mem[c_addr];
    end
    if (reset) begin
      m_pend = 0;
      m_run  = 0;
    end else begin
      m_pend = 0;
      if (w == 1) begin
        m_pend  = 1;
        m_pdata = ref_mem[if_addr];
      end else if (w == 2 && !d_we) begin
        m_pend  = 2;
        m_pdata = ref_mem[d_addr];
      end else if (w == 2) begin
        ref_mem[d_addr] = merge(ref_mem[d_addr], d_wdata, d_be);
      end
      if (w == 1 || !if_req) m_run = 0;
      else if (w == 2) m_run++;
    end
    #1;
  endtask

  logic [7:0] pat;
  int         j;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ref_mem[i] = 32'h5A5A_0000 | 32'(i);
    end
    ref_mem[12'h005] = 32'hDEADBEEF;
    ref_mem[12'h100] = 32'hCAFEF00D;
    ref_mem[12'h7F0] = 32'hAABBCCDD;
    for (int i = 0; i < 4096; i++) mem[i] = ref_mem[i];
    m_run     = 0;
    m_pend    = 0;
    m_pdata   = 32'h0;
    mem_rdata = 32'h0;

    // Reset held with both requesters active.
    reset   = 1'b1;
    if_req  = 1'b1;
    if_addr = 12'h010;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_be    = 4'b1111;
    d_addr  = 12'h020;
    d_wdata = 32'h0;
    for (int c = 0; c < 2; c++) begin
      settle();
      chkb("rst_if_gnt", if_gnt, 1'b0);
      chkb("rst_d_gnt", d_gnt, 1'b0);
      chkb("rst_mem_en", mem_en, 1'b0);
      chkb("rst_if_rvalid", if_rvalid, 1'b0);
      chkb("rst_d_rvalid", d_rvalid, 1'b0);
      tick();
    end
    reset = 1'b0;
    settle();
    chkb("post_rst_d_gnt", d_gnt, 1'b1);
    chkb("post_rst_if_gnt", if_gnt, 1'b0);
    tick();
    d_req = 1'b0;
    settle();
    chkb("post_rst_d_rvalid", d_rvalid, 1'b1);
    chkb("post_rst_if_gnt2", if_gnt, 1'b1);
    tick();
    if_req = 1'b0;
    settle();
    tick();

    // Fetch only.
    if_req  = 1'b1;
    if_addr = 12'h005;
    settle();
    chkb("fetch_gnt", if_gnt, 1'b1);
    chk("fetch_mem_addr", 32'(mem_addr), 32'h005);
    tick();
    if_req = 1'b0;
    settle();
    chkb("fetch_rvalid", if_rvalid, 1'b1);
    chk("fetch_rdata", if_rdata, 32'hDEADBEEF);
    chkb("fetch_no_d_rvalid", d_rvalid, 1'b0);
    tick();

    // Contention: data load wins first, fetch next.
    if_req  = 1'b1;
    if_addr = 12'h006;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 12'h100;
    settle();
    chkb("cont_d_gnt", d_gnt, 1'b1);
    chkb("cont_stall", stall, 1'b1);
    tick();
    d_req = 1'b0;
    settle();
    chkb("cont_if_gnt", if_gnt, 1'b1);
    chkb("cont_d_rvalid", d_rvalid, 1'b1);
    chk("cont_d_rdata", d_rdata, 32'hCAFEF00D);
    tick();
    if_req = 1'b0;
    settle();
    tick();

    // Starvation: four data wins, one fetch, then data again.
    pat     = 8'hEF;
    j       = 0;
    if_req  = 1'b1;
    if_addr = 12'h040;
    d_req   = 1'b1;
    for (int c = 0; c < 8; c++) begin
      d_addr = 12'(12'h200 + j);
      settle();
      chkb("starve_d_gnt", d_gnt, pat[c]);
      chkb("starve_if_gnt", if_gnt, ~pat[c]);
      tick();
      if (pat[c]) j++;
      else if_addr = if_addr + 12'd1;
    end
    d_req  = 1'b0;
    if_req = 1'b0;
    settle();
    tick();

    // Partial store, then read back.
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_be    = 4'b0011;
    d_addr  = 12'h7F0;
    d_wdata = 32'h12345678;
    settle();
    chkb("store_gnt", d_gnt, 1'b1);
    chkb("store_mem_we", mem_we, 1'b1);
    chk("store_mem_be", 32'(mem_be), 32'h3);
    tick();
    d_req = 1'b0;
    d_we  = 1'b0;
    d_be  = 4'b1111;
    settle();
    chkb("store_no_rvalid", d_rvalid, 1'b0);
    tick();
    d_req = 1'b1;
    settle();
    tick();
    d_req = 1'b0;
    settle();
    chkb("load_back_rvalid", d_rvalid, 1'b1);
    chk("load_back_lo", 32'(d_rdata[15:0]), 32'h5678);
    chk("load_back_word", d_rdata, 32'hAABB5678);
    tick();

    // Reset arriving at the edge after a fetch grant drops the response.
    if_req  = 1'b1;
    if_addr = 12'h033;
    settle();
    chkb("midrst_gnt", if_gnt, 1'b1);
    reset = 1'b1;
    tick();
    if_req = 1'b0;
    settle();
    chkb("midrst_if_rvalid", if_rvalid, 1'b0);
    chkb("midrst_d_rvalid", d_rvalid, 1'b0);
    reset = 1'b0;
    tick();
    settle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
